wb_port_arbiter: RTL

Write-port arbiter for the 16-bit register file: shares the single register-file write port between the in-order pipeline writeback stage and the multi-cycle multiply/divide unit (MDU). Pipeline writes always win. MDU results wait in a 2-entry pending buffer and drain on idle cycles. A starvation timer requests a pipeline bubble when an MDU result waits too long. The block sits between the writeback stage outputs and the register file write inputs, and also exports a pending-hit signal for hazard detection.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/wb_port_arbiter_if.sv | 45 ++++
 rtl/wb_port_arbiter_fifo.sv | 89 ++++++++
 rtl/wb_port_arbiter.sv | 92 +++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, writeback request type and helpers
package cpu_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int DATA_W     = 16;
  localparam int AGE_W      = 4;

  // One register-file write: wrn is active-low like the register file port
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
    logic                  wrn;
  } wb_req_t;

  // Saturating increment for the head-age counter
  function automatic logic [AGE_W-1:0] sat_inc(input logic [AGE_W-1:0] v);
    return (v == {AGE_W{1'b1}}) ? v : v + {{(AGE_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - writeback, MDU, register-file and hazard-query signals
interface wb_port_arbiter_if;
  import cpu_pkg::*;

  logic [REG_ADDR_W-1:0] pipe_wreg_addr;
  logic [DATA_W-1:0]     pipe_wreg_data;
  logic                  pipe_reg_wrn;

  logic                  mdu_valid;
  logic                  mdu_ready;
  logic [REG_ADDR_W-1:0] mdu_addr;
  logic [DATA_W-1:0]     mdu_data;

  logic [REG_ADDR_W-1:0] rf_wreg_addr;
  logic [DATA_W-1:0]     rf_wreg_data;
  logic                  rf_reg_wrn;

  logic                  stall_req;

  logic [REG_ADDR_W-1:0] query_addr;
  logic                  pend_hit;

  // Arbiter side
  modport slave (
    input  pipe_wreg_addr, pipe_wreg_data, pipe_reg_wrn,
    input  mdu_valid, mdu_addr, mdu_data,
    output mdu_ready,
    output rf_wreg_addr, rf_wreg_data, rf_reg_wrn,
    output stall_req,
    input  query_addr,
    output pend_hit
  );

  // Pipeline / MDU / register-file side
  modport master (
    output pipe_wreg_addr, pipe_wreg_data, pipe_reg_wrn,
    output mdu_valid, mdu_addr, mdu_data,
    input  mdu_ready,
    input  rf_wreg_addr, rf_wreg_data, rf_reg_wrn,
    input  stall_req,
    output query_addr,
    input  pend_hit
  );

endinterface

// File: rtl/wb_port_arbiter_fifo.sv
// rtl/wb_port_arbiter_fifo.sv - 2-deep pending MDU result buffer with kill-by-address
module wb_pend_fifo
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [REG_ADDR_W-1:0] push_addr_i,
  input  logic [DATA_W-1:0]     push_data_i,
  input  logic                  pop_i,
  input  logic                  kill_i,
  input  logic [REG_ADDR_W-1:0] kill_addr_i,
  input  logic [REG_ADDR_W-1:0] query_addr_i,
  output logic                  head_occ_o,
  output logic                  head_vld_o,
  output logic [REG_ADDR_W-1:0] head_addr_o,
  output logic [DATA_W-1:0]     head_data_o,
  output logic                  full_o,
  output logic                  hit_o
);

  // Slot 0 is always the head; occ marks a slot in use, vld marks it still worth writing
  logic [1:0]                 occ_q, occ_d;
  logic [1:0]                 vld_q, vld_d;
  logic [1:0][REG_ADDR_W-1:0] addr_q, addr_d;
  logic [1:0][DATA_W-1:0]     data_q, data_d;

  assign head_occ_o  = occ_q[0];
  assign head_vld_o  = vld_q[0];
  assign head_addr_o = addr_q[0];
  assign head_data_o = data_q[0];
  assign full_o      = occ_q[1];

  // Hit only looks at registered entries, so a same-cycle push is never reported
  always_comb begin
    hit_o = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (occ_q[i] && vld_q[i] && (addr_q[i] == query_addr_i)) hit_o = 1'b1;
    end
  end

  // Kill older entries first, then shift on pop, then place the push in the first free slot
  always_comb begin
    occ_d  = occ_q;
    vld_d  = vld_q;
    addr_d = addr_q;
    data_d = data_q;
    if (kill_i) begin
      for (int i = 0; i < 2; i++) begin
        if (occ_q[i] && (addr_q[i] == kill_addr_i)) vld_d[i] = 1'b0;
      end
    end
    if (pop_i) begin
      occ_d     = {1'b0, occ_d[1]};
      vld_d     = {1'b0, vld_d[1]};
      addr_d[0] = addr_d[1];
      data_d[0] = data_d[1];
    end
    if (push_i) begin
      if (!occ_d[0]) begin
        occ_d[0]  = 1'b1;
        vld_d[0]  = 1'b1;
        addr_d[0] = push_addr_i;
        data_d[0] = push_data_i;
      end else begin
        occ_d[1]  = 1'b1;
        vld_d[1]  = 1'b1;
        addr_d[1] = push_addr_i;
        data_d[1] = push_data_i;
      end
    end
  end

  // Entry storage; reset discards everything buffered
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q  <= '0;
      vld_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      occ_q  <= occ_d;
      vld_q  <= vld_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write-port arbiter between pipeline and MDU
module wb_port_arbiter
  import cpu_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  wb_port_arbiter_if.slave  bus
);

  logic                  pipe_we;
  logic                  head_occ;
  logic                  head_vld;
  logic [REG_ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0]     head_data;
  logic                  head_kill;
  logic                  head_live;
  logic                  buf_grant;
  logic                  pop;
  logic                  push;
  logic                  full;

  logic [AGE_W-1:0]      age_q, age_d;
  logic                  stall_q, stall_d;
  wb_req_t               rf_q, rf_d;

  assign pipe_we   = ~bus.pipe_reg_wrn;
  // A pipeline write to the head's register makes the buffered result stale
  assign head_kill = pipe_we && head_occ && (head_addr == bus.pipe_wreg_addr);
  assign head_live = head_occ && head_vld && !head_kill;
  assign buf_grant = !pipe_we && head_live;
  // Dead heads leave without using the write port, so they can go even under a pipeline write
  assign pop       = buf_grant || (head_occ && !head_live);
  assign push      = bus.mdu_valid && bus.mdu_ready;

  assign bus.mdu_ready    = ~full;
  assign bus.rf_wreg_addr = rf_q.addr;
  assign bus.rf_wreg_data = rf_q.data;
  assign bus.rf_reg_wrn   = rf_q.wrn;
  assign bus.stall_req    = stall_q;

  wb_pend_fifo u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_addr_i  (bus.mdu_addr),
    .push_data_i  (bus.mdu_data),
    .pop_i        (pop),
    .kill_i       (pipe_we),
    .kill_addr_i  (bus.pipe_wreg_addr),
    .query_addr_i (bus.query_addr),
    .head_occ_o   (head_occ),
    .head_vld_o   (head_vld),
    .head_addr_o  (head_addr),
    .head_data_o  (head_data),
    .full_o       (full),
    .hit_o        (bus.pend_hit)
  );

  // Grant mux, head age and stall request; idle cycles keep the last address/data
  always_comb begin
    rf_d    = '{addr: rf_q.addr, data: rf_q.data, wrn: 1'b1};
    age_d   = age_q;
    stall_d = 1'b0;
    if (pipe_we) begin
      rf_d = '{addr: bus.pipe_wreg_addr, data: bus.pipe_wreg_data, wrn: 1'b0};
    end else if (buf_grant) begin
      rf_d = '{addr: head_addr, data: head_data, wrn: 1'b0};
    end
    if (pop) begin
      age_d = '0;
    end else if (head_live) begin
      age_d   = sat_inc(age_q);
      stall_d = (age_q >= AGE_W'(STARVE_LIMIT));
    end
  end

  // Output and timer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_q    <= '{addr: '0, data: '0, wrn: 1'b1};
      age_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      rf_q    <= rf_d;
      age_q   <= age_d;
      stall_q <= stall_d;
    end
  end

endmodule
